memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller_pkg.sv | 34 +++
 rtl/memory_controller_load_extend.sv | 21 ++
 rtl/memory_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_memory_controller.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_controller_pkg.sv
// Shared global parameters for the memory path: widths, op codes, controller
// state encoding and the per-op access size.
package memory_controller_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int INST_OP_WIDTH  = 6;

  localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd1;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd2;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd3;
  localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd4;
  localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd5;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd6;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd7;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

  localparam logic [XLEN-1:0] IO_ADDR_A = 32'h0003_0000;
  localparam logic [XLEN-1:0] IO_ADDR_B = 32'h0003_0004;

  function automatic logic [2:0] access_bytes(input logic [INST_OP_WIDTH-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: access_bytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: access_bytes = 3'd2;
      default:              access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_load_extend.sv
// Widens an assembled little-endian load word to XLEN: sign extension for
// LB/LH, zero extension for LBU/LHU, pass-through for word accesses.
module mem_load_extend
  import memory_controller_pkg::*;
(
  input  logic [INST_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]          raw,
  output logic [XLEN-1:0]          data
);

  always_comb begin
    case (op)
      OP_LB:   data = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  data = {24'd0, raw[7:0]};
      OP_LH:   data = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// Byte-serial RAM controller arbitrating committed stores, loads and fetches.
// Optional MEM_IO_STORE_WAIT_EN holds UART stores in IDLE while io_buffer_full.
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      io_buffer_full,
  input  logic                      lsb_mem_enable,
  input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
  input  logic [XLEN-1:0]           lsb_mem_addr,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
  input  logic                      rob_store_enable,
  input  logic [INST_OP_WIDTH-1:0]  rob_store_op,
  input  logic [XLEN-1:0]           rob_store_addr,
  input  logic [XLEN-1:0]           rob_store_data,
  input  logic                      if_enable,
  input  logic [XLEN-1:0]           if_addr,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [XLEN-1:0]           mem_a,
  output logic                      mem_wr,
  output logic                      mem_busy,
  output logic                      mem_data_ready,
  output logic [XLEN-1:0]           mem_data,
  output logic [ROB_SIZE_WIDTH-1:0] mem_id,
  output logic                      mem_store_done,
  output logic                      mem_inst_ready,
  output logic [XLEN-1:0]           mem_inst
);

  logic [1:0]                state;
  logic [2:0]                step;
  logic [2:0]                n_bytes;
  logic [INST_OP_WIDTH-1:0]  cur_op;
  logic [XLEN-1:0]           cur_addr;
  logic [XLEN-1:0]           cur_data;
  logic [ROB_SIZE_WIDTH-1:0] cur_id;
  logic                      wr_q;

  logic                      pend_valid;
  logic [INST_OP_WIDTH-1:0]  pend_op;
  logic [XLEN-1:0]           pend_addr;
  logic [ROB_SIZE_WIDTH-1:0] pend_id;

  logic                      st_req;
  logic                      st_wait;
  logic [INST_OP_WIDTH-1:0]  st_op;
  logic [XLEN-1:0]           st_addr;
  logic [XLEN-1:0]           st_data;

`ifdef MEM_IO_STORE_WAIT_EN
  logic                      st_hold;
  logic [INST_OP_WIDTH-1:0]  hold_op;
  logic [XLEN-1:0]           hold_addr;
  logic [XLEN-1:0]           hold_data;

  // A store to the UART ports is parked here until the output buffer drains.
  assign st_req  = rob_store_enable | st_hold;
  assign st_op   = st_hold ? hold_op   : rob_store_op;
  assign st_addr = st_hold ? hold_addr : rob_store_addr;
  assign st_data = st_hold ? hold_data : rob_store_data;
  assign st_wait = st_req && io_buffer_full && (st_addr == IO_ADDR_A || st_addr == IO_ADDR_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_hold   <= 1'b0;
      hold_op   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (rdy && state == ST_IDLE) begin
      st_hold   <= st_wait;
      hold_op   <= st_op;
      hold_addr <= st_addr;
      hold_data <= st_data;
    end
  end
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign st_req  = rob_store_enable;
  assign st_op   = rob_store_op;
  assign st_addr = rob_store_addr;
  assign st_data = rob_store_data;
  assign st_wait = 1'b0;
`endif

  logic                      idle;
  logic                      ld_req;
  logic                      accept_st;
  logic                      accept_ld;
  logic                      accept_if;
  logic                      ld_direct;
  logic [INST_OP_WIDTH-1:0]  ld_op;
  logic [XLEN-1:0]           ld_addr;
  logic [ROB_SIZE_WIDTH-1:0] ld_id;

  assign idle      = (state == ST_IDLE);
  assign ld_req    = pend_valid | lsb_mem_enable;
  assign ld_op     = pend_valid ? pend_op   : lsb_mem_op;
  assign ld_addr   = pend_valid ? pend_addr : lsb_mem_addr;
  assign ld_id     = pend_valid ? pend_id   : lsb_mem_id;
  // Committed stores are accepted even during a flush; loads and fetches are not.
  assign accept_st = idle && st_req && !st_wait;
  assign accept_ld = idle && !flush && !st_req && ld_req;
  assign accept_if = idle && !flush && !st_req && !ld_req && if_enable;
  assign ld_direct = accept_ld && !pend_valid;

  assign mem_busy  = !idle || pend_valid || st_wait;
  assign mem_wr    = wr_q & rdy;

  // Read byte (step-2) arrives on mem_din; merge it into the word being built.
  logic [XLEN-1:0] asm_word;
  logic [XLEN-1:0] ext_word;
  logic [7:0]      st_byte;

  always_comb begin
    asm_word = cur_data;
    case (step)
      3'd2:    asm_word[7:0]   = mem_din;
      3'd3:    asm_word[15:8]  = mem_din;
      3'd4:    asm_word[23:16] = mem_din;
      3'd5:    asm_word[31:24] = mem_din;
      default: ;
    endcase
  end

  assign st_byte = cur_data[{step[1:0], 3'b000} +: 8];

  mem_load_extend u_extend (
    .op   (cur_op),
    .raw  (asm_word),
    .data (ext_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      step           <= '0;
      n_bytes        <= '0;
      cur_op         <= '0;
      cur_addr       <= '0;
      cur_data       <= '0;
      cur_id         <= '0;
      wr_q           <= 1'b0;
      pend_valid     <= 1'b0;
      pend_op        <= '0;
      pend_addr      <= '0;
      pend_id        <= '0;
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_data_ready <= 1'b0;
      mem_data       <= '0;
      mem_id         <= '0;
      mem_store_done <= 1'b0;
      mem_inst_ready <= 1'b0;
      mem_inst       <= '0;
    end else if (rdy) begin
      mem_data_ready <= 1'b0;
      mem_store_done <= 1'b0;
      mem_inst_ready <= 1'b0;

      if (flush) begin
        pend_valid <= 1'b0;
      end else if (lsb_mem_enable && !ld_direct) begin
        pend_valid <= 1'b1;
        pend_op    <= lsb_mem_op;
        pend_addr  <= lsb_mem_addr;
        pend_id    <= lsb_mem_id;
      end else if (accept_ld) begin
        pend_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept_st) begin
            state    <= ST_STORE;
            n_bytes  <= access_bytes(st_op);
            cur_addr <= st_addr;
            cur_data <= st_data;
            step     <= 3'd1;
            mem_a    <= st_addr;
            mem_dout <= st_data[7:0];
            wr_q     <= 1'b1;
          end else if (accept_ld) begin
            state    <= ST_LOAD;
            n_bytes  <= access_bytes(ld_op);
            cur_op   <= ld_op;
            cur_addr <= ld_addr;
            cur_id   <= ld_id;
            cur_data <= '0;
            step     <= 3'd1;
            mem_a    <= ld_addr;
          end else if (accept_if) begin
            state    <= ST_FETCH;
            n_bytes  <= 3'd4;
            cur_op   <= OP_LW;
            cur_addr <= if_addr;
            cur_data <= '0;
            step     <= 3'd1;
            mem_a    <= if_addr;
          end
        end
        ST_STORE: begin
          if (step == n_bytes) begin
            wr_q           <= 1'b0;
            mem_store_done <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            mem_a    <= cur_addr + {29'd0, step};
            mem_dout <= st_byte;
            step     <= step + 3'd1;
          end
        end
        default: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            if (step < n_bytes) mem_a <= cur_addr + {29'd0, step};
            if (step >= 3'd2) cur_data <= asm_word;
            if (step == n_bytes + 3'd1) begin
              state <= ST_IDLE;
              if (state == ST_LOAD) begin
                mem_data_ready <= 1'b1;
                mem_data       <= ext_word;
                mem_id         <= cur_id;
              end else begin
                mem_inst_ready <= 1'b1;
                mem_inst       <= asm_word;
              end
            end else begin
              step <= step + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: byte RAM environment, directed corner cases and
// randomized loads/stores/fetches checked against a transaction-level model.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      rdy;
  logic                      flush;
  logic                      io_buffer_full;
  logic                      lsb_mem_enable;
  logic [INST_OP_WIDTH-1:0]  lsb_mem_op;
  logic [31:0]               lsb_mem_addr;
  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id;
  logic                      rob_store_enable;
  logic [INST_OP_WIDTH-1:0]  rob_store_op;
  logic [31:0]               rob_store_addr;
  logic [31:0]               rob_store_data;
  logic                      if_enable;
  logic [31:0]               if_addr;
  logic [7:0]                mem_din;
  logic [7:0]                mem_dout;
  logic [31:0]               mem_a;
  logic                      mem_wr;
  logic                      mem_busy;
  logic                      mem_data_ready;
  logic [31:0]               mem_data;
  logic [ROB_SIZE_WIDTH-1:0] mem_id;
  logic                      mem_store_done;
  logic                      mem_inst_ready;
  logic [31:0]               mem_inst;

  int n_cmp;
  int n_err;

  logic [7:0]  ram     [0:262143];
  logic [7:0]  ref_mem [0:262143];
  logic [39:0] wr_log  [$];
  logic [31:0] exp_q   [$];

  memory_controller dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .flush            (flush),
    .io_buffer_full   (io_buffer_full),
    .lsb_mem_enable   (lsb_mem_enable),
    .lsb_mem_op       (lsb_mem_op),
    .lsb_mem_addr     (lsb_mem_addr),
    .lsb_mem_id       (lsb_mem_id),
    .rob_store_enable (rob_store_enable),
    .rob_store_op     (rob_store_op),
    .rob_store_addr   (rob_store_addr),
    .rob_store_data   (rob_store_data),
    .if_enable        (if_enable),
    .if_addr          (if_addr),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr),
    .mem_busy         (mem_busy),
    .mem_data_ready   (mem_data_ready),
    .mem_data         (mem_data),
    .mem_id           (mem_id),
    .mem_store_done   (mem_store_done),
    .mem_inst_ready   (mem_inst_ready),
    .mem_inst         (mem_inst)
  );

  // ---------------- clock / reset / environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      wr_log.push_back({mem_a, mem_dout});
    end
    mem_din <= ram[mem_a[17:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking and reference model ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [INST_OP_WIDTH-1:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] addr);
    logic [31:0] w;
    w = 0;
    for (int i = 0; i < nbytes(op); i++)
      w = w + (32'(ref_mem[addr[17:0] + 18'(i)]) << (8 * i));
    if (op == OP_LB && w >= 32'd128)   w = w - 32'd256;
    if (op == OP_LH && w >= 32'd32768) w = w - 32'd65536;
    return w;
  endfunction

  task automatic ref_store(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < nbytes(op); i++)
      ref_mem[addr[17:0] + 18'(i)] = data[8*i +: 8];
  endtask

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    ram[addr[17:0]]     = b;
    ref_mem[addr[17:0]] = b;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    lsb_mem_enable   = 1'b0;
    rob_store_enable = 1'b0;
    if_enable        = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic do_load(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] addr,
                         input logic [ROB_SIZE_WIDTH-1:0] id, input logic [31:0] exp);
    int n;
    n = nbytes(op);
    exp_q.push_back(exp);
    lsb_mem_enable = 1'b1;
    lsb_mem_op     = op;
    lsb_mem_addr   = addr;
    lsb_mem_id     = id;
    tick();
    lsb_mem_enable = 1'b0;
    check("ld_a0", mem_a, addr);
    for (int e = 1; e <= n; e++) begin
      check("ld_busy", 32'(mem_busy), 1);
      tick();
      if (e < n) check("ld_a", mem_a, addr + 32'(e));
      check("ld_early", 32'(mem_data_ready), 0);
    end
    tick();
    check("ld_ready", 32'(mem_data_ready), 1);
    check("ld_data", mem_data, exp_q.pop_front());
    check("ld_id", 32'(mem_id), 32'(id));
    check("ld_idle", 32'(mem_busy), 0);
    tick();
    check("ld_pulse", 32'(mem_data_ready), 0);
  endtask

  task automatic do_store(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = nbytes(op);
    ref_store(op, addr, data);
    rob_store_enable = 1'b1;
    rob_store_op     = op;
    rob_store_addr   = addr;
    rob_store_data   = data;
    tick();
    rob_store_enable = 1'b0;
    for (int e = 0; e < n; e++) begin
      if (e > 0) tick();
      check("st_wr", 32'(mem_wr), 1);
      check("st_addr", mem_a, addr + 32'(e));
      check("st_byte", 32'(mem_dout), (data >> (8 * e)) & 32'hFF);
      check("st_done_early", 32'(mem_store_done), 0);
    end
    tick();
    check("st_wr_end", 32'(mem_wr), 0);
    check("st_done", 32'(mem_store_done), 1);
    tick();
    check("st_done_pulse", 32'(mem_store_done), 0);
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    exp_q.push_back(ref_load(OP_LW, addr));
    if_enable = 1'b1;
    if_addr   = addr;
    tick();
    if_enable = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("if_early", 32'(mem_inst_ready), 0);
    end
    tick();
    check("if_ready", 32'(mem_inst_ready), 1);
    check("if_data", mem_inst, exp_q.pop_front());
    tick();
    check("if_pulse", 32'(mem_inst_ready), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [INST_OP_WIDTH-1:0] ld_ops [5];
    logic [INST_OP_WIDTH-1:0] st_ops [3];
    logic [31:0] d;
    logic [31:0] a;
    int saw;
    int seen_done;
    int seen_rdy;

    ld_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    st_ops = '{OP_SB, OP_SH, OP_SW};
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 262144; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    quiet_inputs();
    rdy = 1'b1;
    io_buffer_full = 1'b0;
    lsb_mem_op = '0; lsb_mem_addr = '0; lsb_mem_id = '0;
    rob_store_op = '0; rob_store_addr = '0; rob_store_data = '0;
    if_addr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", mem_a, 0);
    check("rst_dout", 32'(mem_dout), 0);
    check("rst_wr", 32'(mem_wr), 0);
    check("rst_busy", 32'(mem_busy), 0);
    check("rst_dready", 32'(mem_data_ready), 0);
    check("rst_data", mem_data, 0);
    check("rst_id", 32'(mem_id), 0);
    check("rst_sdone", 32'(mem_store_done), 0);
    check("rst_iready", 32'(mem_inst_ready), 0);
    check("rst_inst", mem_inst, 0);
    rst = 1'b0;
    tick();

    // LW little-endian assembly
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    do_load(OP_LW, 32'h100, 4'd5, 32'h1234_5678);
    // LB / LBU of 0x80
    poke(32'h104, 8'h80);
    do_load(OP_LB, 32'h104, 4'd1, 32'hFFFF_FF80);
    do_load(OP_LBU, 32'h104, 4'd2, 32'h0000_0080);
    // SH byte order
    do_store(OP_SH, 32'h200, 32'h0000_BEEF);
    check("sh_ram0", 32'(ram[18'h200]), 32'hEF);
    check("sh_ram1", 32'(ram[18'h201]), 32'hBE);

    // Store, load and fetch in the same cycle: store wins, load waits, fetch dropped
    d = $urandom;
    ref_store(OP_SW, 32'h400, d);
    wr_log.delete();
    rob_store_enable = 1'b1; rob_store_op = OP_SW; rob_store_addr = 32'h400; rob_store_data = d;
    lsb_mem_enable = 1'b1; lsb_mem_op = OP_LW; lsb_mem_addr = 32'h300; lsb_mem_id = 4'd7;
    if_enable = 1'b1; if_addr = 32'h0;
    tick();
    quiet_inputs();
    check("sc_store_first", 32'(mem_wr), 1);
    check("sc_store_addr", mem_a, 32'h400);
    saw = 0; seen_done = 0;
    for (int c = 0; c < 20 && saw == 0; c++) begin
      check("sc_busy", 32'(mem_busy), 1);
      tick();
      if (mem_store_done) seen_done = 1;
      if (mem_data_ready) saw = 1;
    end
    check("sc_load_served", 32'(saw), 1);
    check("sc_store_done", 32'(seen_done), 1);
    check("sc_data", mem_data, ref_load(OP_LW, 32'h300));
    check("sc_id", 32'(mem_id), 7);
    check("sc_writes", 32'(wr_log.size()), 4);
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_inst_ready) saw = 1;
    end
    check("sc_fetch_dropped", 32'(saw), 0);

    // Flush at byte 2 of a LW
    lsb_mem_enable = 1'b1; lsb_mem_op = OP_LW; lsb_mem_addr = 32'h500; lsb_mem_id = 4'd3;
    tick();
    lsb_mem_enable = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ld_idle", 32'(mem_busy), 0);
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_data_ready) saw = 1;
    end
    check("fl_ld_no_ready", 32'(saw), 0);

    // Flush at byte 2 of a SW: all four bytes still written
    d = $urandom;
    ref_store(OP_SW, 32'h600, d);
    wr_log.delete();
    rob_store_enable = 1'b1; rob_store_op = OP_SW; rob_store_addr = 32'h600; rob_store_data = d;
    tick();
    rob_store_enable = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_st_wr", 32'(mem_wr), 1);
    tick();
    tick();
    check("fl_st_done", 32'(mem_store_done), 1);
    check("fl_st_writes", 32'(wr_log.size()), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      check("fl_st_log", 32'(wr_log[i][7:0]), (d >> (8 * i)) & 32'hFF);

    // UART store with the output buffer full for three cycles
    d = 32'($urandom_range(0, 255));
    ref_store(OP_SB, IO_ADDR_A, d);
    wr_log.delete();
    io_buffer_full = 1'b1;
    rob_store_enable = 1'b1; rob_store_op = OP_SB; rob_store_addr = IO_ADDR_A; rob_store_data = d;
    tick();
    rob_store_enable = 1'b0;
`ifdef MEM_IO_STORE_WAIT_EN
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      check("io_wait_wr", 32'(mem_wr), 0);
      check("io_wait_busy", 32'(mem_busy), 1);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_wr", 32'(mem_wr), 1);
    check("io_addr", mem_a, IO_ADDR_A);
    check("io_byte", 32'(mem_dout), d);
    tick();
    check("io_done", 32'(mem_store_done), 1);
`else
    check("io_wr", 32'(mem_wr), 1);
    check("io_addr", mem_a, IO_ADDR_A);
    check("io_byte", 32'(mem_dout), d);
    tick();
    check("io_done", 32'(mem_store_done), 1);
    tick();
    io_buffer_full = 1'b0;
`endif
    check("io_writes", 32'(wr_log.size()), 1);
    tick();

    // rdy low mid-store: no writes, state held, then resumes
    d = $urandom;
    ref_store(OP_SW, 32'h700, d);
    wr_log.delete();
    rob_store_enable = 1'b1; rob_store_op = OP_SW; rob_store_addr = 32'h700; rob_store_data = d;
    tick();
    rob_store_enable = 1'b0;
    tick();
    rdy = 1'b0;
    #1;
    check("rdy_wr_forced", 32'(mem_wr), 0);
    tick();
    check("rdy_hold_a", mem_a, 32'h701);
    check("rdy_hold_wr", 32'(mem_wr), 0);
    tick();
    rdy = 1'b1;
    tick();
    tick();
    check("rdy_no_done", 32'(mem_store_done), 0);
    tick();
    check("rdy_done", 32'(mem_store_done), 1);
    check("rdy_writes", 32'(wr_log.size()), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      check("rdy_log", 32'(wr_log[i][39:8]), 32'h700 + 32'(i));

    // Reset in the middle of a store abandons it
    rob_store_enable = 1'b1; rob_store_op = OP_SW; rob_store_addr = 32'h800; rob_store_data = $urandom;
    tick();
    rob_store_enable = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mrst_wr", 32'(mem_wr), 0);
    check("mrst_busy", 32'(mem_busy), 0);
    check("mrst_a", mem_a, 0);
    tick();
    rst = 1'b0;
    wr_log.delete();
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_store_done) seen_done = 1;
    end
    check("mrst_no_done", 32'(seen_done), 0);
    check("mrst_no_writes", 32'(wr_log.size()), 0);

    // Randomized traffic against the reference image
    for (int t = 0; t < 40; t++) begin
      a = 32'h1000 + 32'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: begin
          logic [INST_OP_WIDTH-1:0] op;
          op = ld_ops[$urandom_range(0, 4)];
          do_load(op, a, 4'($urandom_range(0, 15)), ref_load(op, a));
        end
        1: do_store(st_ops[$urandom_range(0, 2)], a, $urandom);
        default: do_fetch(a);
      endcase
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("rnd_idle", 32'(mem_busy), 0);
      end
    end

    seen_rdy = exp_q.size();
    check("scoreboard_empty", 32'(seen_rdy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
